// File: rtl/puf_pkg.sv
// Shared types and default sizes for the PUF response capture path.
package puf_pkg;

    localparam int N_BITS_DEF = 256;
    localparam int CHAL_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEAS,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/puf_wait_timer.sv
// Loadable down-counter with a zero flag; shared by the settle and timeout waits.
module puf_wait_timer
    import puf_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/puf_response_sequencer.sv
// Walks the challenge index through every RO pair, measures each one and
// streams the response bits into the external shift register, challenge 0 first.
module puf_response_sequencer
    import puf_pkg::*;
#(
    parameter int N_BITS         = N_BITS_DEF,
    parameter int CHAL_W         = CHAL_W_DEF,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CHAL_W-1:0] chal,
    output logic              meas_start,
    input  logic              meas_done,
    input  logic              resp_bit,
    output logic              sr_s_in,
    output logic              sr_en
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    // Timer is loaded with N-1 so its zero flag marks the N-th cycle in the state.
    localparam logic [TMR_W-1:0]  SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TIMEOUT_LD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CHAL_W-1:0] LAST_CHAL  = CHAL_W'(N_BITS - 1);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic              meas_start_q, meas_start_d;
    logic              sr_s_in_q, sr_s_in_d;
    logic              sr_en_q, sr_en_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_dec;
    logic              tmr_zero;

    puf_wait_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        chal_d       = chal_q;
        meas_start_d = 1'b0;
        sr_s_in_d    = sr_s_in_q;
        sr_en_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = SETTLE_LD;
        tmr_dec      = 1'b0;

        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        chal_d   = '0;
                        err_d    = 1'b0;
                        done_d   = 1'b0;
                        busy_d   = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        meas_start_d = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = TIMEOUT_LD;
                        state_d      = MEAS;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                MEAS: begin
                    // A response arriving on the expiry cycle still counts.
                    if (meas_done) begin
                        sr_s_in_d = resp_bit;
                        sr_en_d   = 1'b1;
                        state_d   = SHIFT;
                    end else if (tmr_zero) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                SHIFT: begin
                    if (chal_q == LAST_CHAL) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        chal_d   = chal_q + CHAL_W'(1);
                        tmr_load = 1'b1;
                        state_d  = SETTLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            chal_q       <= '0;
            meas_start_q <= 1'b0;
            sr_s_in_q    <= 1'b0;
            sr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            chal_q       <= chal_d;
            meas_start_q <= meas_start_d;
            sr_s_in_q    <= sr_s_in_d;
            sr_en_q      <= sr_en_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign chal       = chal_q;
    assign meas_start = meas_start_q;
    assign sr_s_in    = sr_s_in_q;
    assign sr_en      = sr_en_q;

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Scoreboard bench for puf_response_sequencer with a delayed comparator model
// and an 8-bit shift register model.
module tb_puf_response_sequencer;

    localparam int N_BITS   = 8;
    localparam int CHAL_W   = 3;
    localparam int SETTLE   = 4;
    localparam int TIMEOUT  = 20;
    localparam int RESP_DLY = 5;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort;
    logic              meas_done;
    logic              resp_bit;
    logic              busy, done, err, meas_start, sr_s_in, sr_en;
    logic [CHAL_W-1:0] chal;

    logic cmp_done   = 1'b0;
    logic cmp_bit    = 1'b0;
    logic cmp_abort  = 1'b0;
    logic stray_done = 1'b0;

    assign meas_done = cmp_done | stray_done;
    assign resp_bit  = cmp_bit;
    assign abort     = cmp_abort;

    int n_tests     = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int shift_cnt   = 0;
    int silent_chal = -1;
    int abort_chal  = -1;

    logic [CHAL_W:0] exp_q[$];
    logic [7:0]      sr_model = 8'h00;

    puf_response_sequencer #(
        .N_BITS         (N_BITS),
        .CHAL_W         (CHAL_W),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .chal       (chal),
        .meas_start (meas_start),
        .meas_done  (meas_done),
        .resp_bit   (resp_bit),
        .sr_s_in    (sr_s_in),
        .sr_en      (sr_en)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Comparator model: answers chal[0] RESP_DLY cycles after meas_start.
    always begin : cmp_model
        logic b;
        logic ab;
        @(negedge clk);
        if (meas_start === 1'b1 && int'(chal) != silent_chal) begin
            b  = chal[0];
            ab = (int'(chal) == abort_chal);
            repeat (RESP_DLY - 1) @(negedge clk);
            cmp_done  = 1'b1;
            cmp_bit   = b;
            cmp_abort = ab;
            @(negedge clk);
            cmp_done  = 1'b0;
            cmp_abort = 1'b0;
        end
    end

    // Monitor: settle spacing, meas_start width, and scoreboard pops on sr_en.
    always begin : monitor
        logic              prev_busy;
        logic              prev_ms;
        logic [CHAL_W-1:0] prev_chal;
        logic [CHAL_W:0]   e;
        int                mark;
        prev_busy = 1'b0;
        prev_ms   = 1'b0;
        prev_chal = '0;
        mark      = 0;
        forever begin
            @(negedge clk);
            if ((busy && !prev_busy) || (chal != prev_chal)) mark = cyc;
            if (meas_start === 1'b1) begin
                check("settle_gap", cyc - mark, SETTLE);
                check("meas_start_width", prev_ms, 0);
            end
            if (sr_en === 1'b1) begin
                shift_cnt++;
                sr_model = {sr_model[6:0], sr_s_in};
                check("shift_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("shift_bit", sr_s_in, e[0]);
                    check("shift_chal", chal, e[CHAL_W:1]);
                end
            end
            prev_busy = busy;
            prev_ms   = meas_start;
            prev_chal = chal;
        end
    end

    task automatic push_capture(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({CHAL_W'(k), 1'(k & 1)});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, done, 1);
    endtask

    task automatic wait_chal(input string name, input int value, input int budget);
        int k;
        k = 0;
        while (int'(chal) != value && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_chal_reached"}, chal, value);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int t0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_chal", chal, 0);
        check("rst_meas_start", meas_start, 0);
        check("rst_sr_s_in", sr_s_in, 0);
        check("rst_sr_en", sr_en, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal full capture
        base = shift_cnt;
        push_capture(N_BITS);
        pulse_start();
        check("nom_busy_start", busy, 1);
        wait_done("nom", 300);
        check("nom_busy", busy, 0);
        check("nom_err", err, 0);
        check("nom_chal", chal, N_BITS - 1);
        check("nom_sr", sr_model, 8'h55);
        check("nom_shifts", shift_cnt - base, N_BITS);
        check("nom_queue", exp_q.size(), 0);

        // Comparator silent at challenge 3
        base = shift_cnt;
        push_capture(3);
        silent_chal = 3;
        pulse_start();
        k = 0;
        while (!(meas_start === 1'b1 && chal == 3) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("to_meas3_seen", meas_start, 1);
        t0 = cyc;
        k = 0;
        while (err !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("to_cycles", cyc - t0, TIMEOUT);
        check("to_err", err, 1);
        check("to_done", done, 1);
        check("to_busy", busy, 0);
        check("to_chal", chal, 3);
        check("to_shifts", shift_cnt - base, 3);
        check("to_queue", exp_q.size(), 0);
        silent_chal = -1;
        base = shift_cnt;
        push_capture(N_BITS);
        pulse_start();
        check("restart_err", err, 0);
        check("restart_chal", chal, 0);
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);
        wait_done("restart", 300);
        check("restart_sr", sr_model, 8'h55);
        check("restart_shifts", shift_cnt - base, N_BITS);

        // Abort at challenge 5 together with meas_done
        base = shift_cnt;
        push_capture(5);
        abort_chal = 5;
        pulse_start();
        k = 0;
        while (cmp_abort !== 1'b1 && k < 300) begin
            @(posedge clk);
            k++;
        end
        check("abort_seen", cmp_abort, 1);
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sr_en", sr_en, 0);
        check("abort_meas_start", meas_start, 0);
        check("abort_chal", chal, 5);
        abort_chal = -1;
        repeat (10) @(negedge clk);
        check("abort_shifts", shift_cnt - base, 5);
        check("abort_queue", exp_q.size(), 0);
        check("abort_idle_busy", busy, 0);

        // Asynchronous reset in SETTLE at challenge 2
        base = shift_cnt;
        push_capture(2);
        pulse_start();
        wait_chal("arst", 2, 300);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_chal", chal, 0);
        check("arst_meas_start", meas_start, 0);
        check("arst_sr_s_in", sr_s_in, 0);
        check("arst_sr_en", sr_en, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_shifts", shift_cnt - base, 2);
        check("arst_queue", exp_q.size(), 0);
        base = shift_cnt;
        push_capture(N_BITS);
        pulse_start();
        check("arst_restart_chal", chal, 0);
        wait_done("arst_restart", 300);
        check("arst_restart_sr", sr_model, 8'h55);
        check("arst_restart_shifts", shift_cnt - base, N_BITS);
        check("arst_restart_err", err, 0);

        // start while busy and stray meas_done in SETTLE
        base = shift_cnt;
        push_capture(N_BITS);
        pulse_start();
        wait_chal("busy", 1, 300);
        start      = 1'b1;
        stray_done = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        stray_done = 1'b0;
        check("busy_still_busy", busy, 1);
        check("busy_chal_held", chal, 1);
        wait_done("busy", 300);
        check("busy_shifts", shift_cnt - base, N_BITS);
        check("busy_sr", sr_model, 8'h55);
        check("busy_err", err, 0);
        check("busy_chal", chal, N_BITS - 1);
        check("busy_queue", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
